// File: rtl/dbus_access_seq_if.sv
// Data-bus request/response bundle between the memory-stage sequencer and the dbus.
// The master modport is the sequencer side, the slave modport is the bus side.
interface dbus_access_seq_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                dreq_valid;
    logic [ADDR_W-1:0]   dreq_addr;
    logic [2:0]          dreq_size;
    logic [DATA_W/8-1:0] dreq_strobe;
    logic [DATA_W-1:0]   dreq_data;
    logic                dresp_addr_ok;
    logic                dresp_data_ok;
    logic [DATA_W-1:0]   dresp_data;

    modport master (
        output dreq_valid,
        output dreq_addr,
        output dreq_size,
        output dreq_strobe,
        output dreq_data,
        input  dresp_addr_ok,
        input  dresp_data_ok,
        input  dresp_data
    );

    modport slave (
        input  dreq_valid,
        input  dreq_addr,
        input  dreq_size,
        input  dreq_strobe,
        input  dreq_data,
        output dresp_addr_ok,
        output dresp_data_ok,
        output dresp_data
    );
endinterface

// File: rtl/dbus_access_seq.sv
// Memory-stage data-bus sequencer: issues one load/store, stalls while it is outstanding, holds the read word.
// Define DBUS_SEQ_ALIGN_CHECK_EN to trap misaligned halfword/word accesses (adds misalign_o).
module dbus_access_seq #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_valid_i,
    input  logic                mem_write_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [2:0]          mem_size_i,
    input  logic [DATA_W/8-1:0] mem_strobe_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic                mem_advance_i,
    input  logic                flush_i,
    dbus_access_seq_if.master   dbus,
    output logic                stall_req_o,
    output logic                rdata_valid_o,
    output logic [DATA_W-1:0]   rdata_o
`ifdef DBUS_SEQ_ALIGN_CHECK_EN
    ,
    output logic                misalign_o
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        DONE,
        DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [DATA_W/8-1:0] strobe_q, strobe_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic                addr_acc_q, addr_acc_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                req_valid;
    logic [ADDR_W-1:0]   req_addr;
    logic [2:0]          req_size;
    logic [DATA_W/8-1:0] req_strobe;
    logic [DATA_W-1:0]   req_data;
    logic                stall_req;
    logic                misaligned;
    logic                trapped;

`ifdef DBUS_SEQ_ALIGN_CHECK_EN
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;

    logic misalign_q, misalign_d;

    always_comb begin
        misaligned = ((mem_size_i == MSIZE2) && mem_addr_i[0]) ||
                     ((mem_size_i == MSIZE4) && (mem_addr_i[1:0] != 2'b00));
    end

    // A trapped access parks in DONE without touching the bus; the flag lives as long as DONE does.
    always_comb begin
        misalign_d = misalign_q;
        if ((state_q == IDLE) && mem_valid_i && !flush_i && misaligned) begin
            misalign_d = 1'b1;
        end else if ((state_q == DONE) && (state_d != DONE)) begin
            misalign_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
    assign trapped    = misalign_q;
`else
    assign misaligned = 1'b0;
    assign trapped    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        strobe_d   = strobe_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        addr_acc_d = addr_acc_q;
        rdata_d    = rdata_q;
        req_valid  = 1'b0;
        req_addr   = addr_q;
        req_size   = size_q;
        req_strobe = strobe_q;
        req_data   = wdata_q;
        stall_req  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_valid_i && !flush_i) begin
                    if (misaligned) begin
                        state_d = DONE;
                    end else begin
                        // Issue straight from the pipeline inputs so a fast bus finishes in one stall cycle.
                        req_valid  = 1'b1;
                        stall_req  = 1'b1;
                        req_addr   = mem_addr_i;
                        req_size   = mem_size_i;
                        req_strobe = mem_write_i ? mem_strobe_i : '0;
                        req_data   = mem_wdata_i;
                        addr_d     = mem_addr_i;
                        size_d     = mem_size_i;
                        strobe_d   = mem_write_i ? mem_strobe_i : '0;
                        wdata_d    = mem_wdata_i;
                        write_d    = mem_write_i;
                        addr_acc_d = 1'b0;
                        if (dbus.dresp_addr_ok && dbus.dresp_data_ok) begin
                            if (!mem_write_i) begin
                                rdata_d = dbus.dresp_data;
                            end
                            state_d = DONE;
                        end else if (dbus.dresp_addr_ok) begin
                            addr_acc_d = 1'b1;
                            state_d    = DATA;
                        end else begin
                            state_d = ADDR;
                        end
                    end
                end
            end

            ADDR: begin
                req_valid = 1'b1;
                stall_req = 1'b1;
                if (dbus.dresp_addr_ok && dbus.dresp_data_ok) begin
                    if (flush_i) begin
                        state_d = IDLE;
                    end else begin
                        if (!write_q) begin
                            rdata_d = dbus.dresp_data;
                        end
                        state_d = DONE;
                    end
                end else if (dbus.dresp_addr_ok) begin
                    addr_acc_d = 1'b1;
                    state_d    = flush_i ? DRAIN : DATA;
                end else if (flush_i) begin
                    addr_acc_d = 1'b0;
                    state_d    = DRAIN;
                end
            end

            DATA: begin
                stall_req = 1'b1;
                if (dbus.dresp_data_ok) begin
                    if (flush_i) begin
                        state_d = IDLE;
                    end else begin
                        if (!write_q) begin
                            rdata_d = dbus.dresp_data;
                        end
                        state_d = DONE;
                    end
                end else if (flush_i) begin
                    addr_acc_d = 1'b1;
                    state_d    = DRAIN;
                end
            end

            DONE: begin
                if (mem_advance_i || flush_i) begin
                    state_d = IDLE;
                end
            end

            // Killed access: the bus cannot cancel, so finish the handshake but discard the result.
            DRAIN: begin
                stall_req = 1'b1;
                req_valid = !addr_acc_q;
                if (!addr_acc_q) begin
                    if (dbus.dresp_addr_ok && dbus.dresp_data_ok) begin
                        state_d = IDLE;
                    end else if (dbus.dresp_addr_ok) begin
                        addr_acc_d = 1'b1;
                    end
                end else if (dbus.dresp_data_ok) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            strobe_q   <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            addr_acc_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            strobe_q   <= strobe_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            addr_acc_q <= addr_acc_d;
            rdata_q    <= rdata_d;
        end
    end

    assign dbus.dreq_valid  = req_valid;
    assign dbus.dreq_addr   = req_addr;
    assign dbus.dreq_size   = req_size;
    assign dbus.dreq_strobe = req_strobe;
    assign dbus.dreq_data   = req_data;

    assign stall_req_o   = stall_req;
    assign rdata_valid_o = (state_q == DONE) && !write_q && !trapped;
    assign rdata_o       = rdata_q;

endmodule

// File: tb/tb_dbus_access_seq.sv
// Directed bench for dbus_access_seq: stimulus pushes expected bus requests and read words,
// a negedge monitor pops and compares them when the DUT handshakes or raises rdata_valid.
module tb_dbus_access_seq;

   localparam logic [2:0] MSIZE2 = 3'd1;
   localparam logic [2:0] MSIZE4 = 3'd2;

   typedef struct packed {
      logic        rstn;
      logic        mv;
      logic        mw;
      logic [31:0] a;
      logic [2:0]  sz;
      logic [3:0]  st;
      logic [31:0] wd;
      logic        adv;
      logic        fl;
      logic        aok;
      logic        dok;
      logic [31:0] rd;
   } stim_t;

   typedef struct packed {
      logic [31:0] a;
      logic [2:0]  sz;
      logic [3:0]  st;
      logic [31:0] wd;
   } req_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        memValid;
   logic        memWrite;
   logic [31:0] memAddr;
   logic [2:0]  memSize;
   logic [3:0]  memStrobe;
   logic [31:0] memWdata;
   logic        memAdvance;
   logic        flush;
   logic        stallReq;
   logic        rdataValid;
   logic [31:0] rdata;
`ifdef DBUS_SEQ_ALIGN_CHECK_EN
   logic        misalign;
`endif

   int          checkCount = 0;
   int          passCount  = 0;
   req_t        reqQ[$];
   logic [31:0] respQ[$];
   logic        prevRv = 1'b0;
   req_t        monReq;
   logic [31:0] monWord;

   dbus_access_seq_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dbus_access_seq #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .mem_valid_i   (memValid),
      .mem_write_i   (memWrite),
      .mem_addr_i    (memAddr),
      .mem_size_i    (memSize),
      .mem_strobe_i  (memStrobe),
      .mem_wdata_i   (memWdata),
      .mem_advance_i (memAdvance),
      .flush_i       (flush),
      .dbus          (bus.master),
      .stall_req_o   (stallReq),
      .rdata_valid_o (rdataValid),
      .rdata_o       (rdata)
`ifdef DBUS_SEQ_ALIGN_CHECK_EN
      ,
      .misalign_o    (misalign)
`endif
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Hard stop in case something stalls the stimulus forever
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   function automatic stim_t idleStim();
      stim_t s;
      s = '0;
      s.rstn = 1'b1;
      return s;
   endfunction

   // One cycle: drive just after the rising edge, return at the falling edge for sampling
   task automatic applyStimulus(input stim_t s);
      @(posedge clk);
      #1;
      resetn            = s.rstn;
      memValid          = s.mv;
      memWrite          = s.mw;
      memAddr           = s.a;
      memSize           = s.sz;
      memStrobe         = s.st;
      memWdata          = s.wd;
      memAdvance        = s.adv;
      flush             = s.fl;
      bus.dresp_addr_ok = s.aok;
      bus.dresp_data_ok = s.dok;
      bus.dresp_data    = s.rd;
      @(negedge clk);
   endtask

   // Run one access until the DUT drops stall (DONE), with bus waits given by the delays
   task automatic doAccess(input stim_t base, input int addrDelay, input int dataDelay,
                           input logic [31:0] word, output int stallCyc, output int reqCyc,
                           output bit addrStable);
      stim_t s;
      bit    done;
      stallCyc   = 0;
      reqCyc     = 0;
      addrStable = 1'b1;
      done       = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         s     = base;
         s.aok = (k == addrDelay);
         s.dok = (k == addrDelay + dataDelay);
         s.rd  = s.dok ? word : 32'h0;
         applyStimulus(s);
         if (!stallReq) begin
            done = 1'b1;
            checkOutput("done_no_request", 96'(bus.dreq_valid), 96'(0));
         end else begin
            stallCyc++;
            if (bus.dreq_valid) begin
               reqCyc++;
               if (bus.dreq_addr !== base.a) addrStable = 1'b0;
            end
         end
      end
      if (!done) checkOutput("access_timeout", 96'(0), 96'(1));
   endtask

   // Scoreboard monitor
   initial begin
      forever begin
         @(negedge clk);
         if (resetn === 1'b1 && bus.dreq_valid === 1'b1 && bus.dresp_addr_ok === 1'b1) begin
            if (reqQ.size() == 0) begin
               checkOutput("req_unexpected", 96'(1), 96'(0));
            end else begin
               monReq = reqQ.pop_front();
               checkOutput("req_fields",
                           96'({bus.dreq_addr, bus.dreq_size, bus.dreq_strobe, bus.dreq_data}),
                           96'({monReq.a, monReq.sz, monReq.st, monReq.wd}));
            end
         end
         if (rdataValid === 1'b1 && !prevRv) begin
            if (respQ.size() == 0) begin
               checkOutput("rvalid_unexpected", 96'(1), 96'(0));
            end else begin
               monWord = respQ.pop_front();
               checkOutput("rdata_word", 96'(rdata), 96'(monWord));
            end
         end
         prevRv = (rdataValid === 1'b1);
      end
   end

   initial begin
      stim_t s;
      int    sc;
      int    rc;
      bit    stable;

      resetn            = 1'b0;
      memValid          = 1'b0;
      memWrite          = 1'b0;
      memAddr           = '0;
      memSize           = '0;
      memStrobe         = '0;
      memWdata          = '0;
      memAdvance        = 1'b0;
      flush             = 1'b0;
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      bus.dresp_data    = '0;

      s = idleStim();
      s.rstn = 1'b0;
      applyStimulus(s);
      applyStimulus(s);
      checkOutput("rst_stall", 96'(stallReq), 96'(0));
      checkOutput("rst_dreq_valid", 96'(bus.dreq_valid), 96'(0));
      checkOutput("rst_rvalid", 96'(rdataValid), 96'(0));
      checkOutput("rst_rdata", 96'(rdata), 96'(0));
`ifdef DBUS_SEQ_ALIGN_CHECK_EN
      checkOutput("rst_misalign", 96'(misalign), 96'(0));
`endif
      applyStimulus(idleStim());

      // Single-cycle load; strobe driven high must be masked for a load
      $display("[TB] load with immediate handshake");
      s = idleStim();
      s.mv = 1'b1; s.a = 32'h80000004; s.sz = MSIZE4; s.st = 4'hF;
      reqQ.push_back('{a: 32'h80000004, sz: MSIZE4, st: 4'h0, wd: 32'h0});
      respQ.push_back(32'hDEADBEEF);
      doAccess(s, 0, 0, 32'hDEADBEEF, sc, rc, stable);
      checkOutput("t1_stall_cycles", 96'(sc), 96'(1));
      applyStimulus(s);
      checkOutput("t1_rvalid_hold", 96'(rdataValid), 96'(1));
      checkOutput("t1_rdata_hold", 96'(rdata), 96'(32'hDEADBEEF));
      s.adv = 1'b1;
      applyStimulus(s);
      checkOutput("t1_rvalid_adv_cycle", 96'(rdataValid), 96'(1));
      applyStimulus(idleStim());
      checkOutput("t1_rvalid_clear", 96'(rdataValid), 96'(0));
      checkOutput("t1_rdata_kept", 96'(rdata), 96'(32'hDEADBEEF));

      // Slow bus: addr_ok after 3 wait cycles, data_ok 2 cycles later
      $display("[TB] load with bus wait states");
      s = idleStim();
      s.mv = 1'b1; s.a = 32'h00001000; s.sz = MSIZE4;
      reqQ.push_back('{a: 32'h00001000, sz: MSIZE4, st: 4'h0, wd: 32'h0});
      respQ.push_back(32'hCAFEF00D);
      doAccess(s, 3, 2, 32'hCAFEF00D, sc, rc, stable);
      checkOutput("t2_req_cycles", 96'(rc), 96'(4));
      checkOutput("t2_stall_cycles", 96'(sc), 96'(6));
      checkOutput("t2_addr_stable", 96'(stable), 96'(1));
      s.adv = 1'b1;
      applyStimulus(s);
      applyStimulus(idleStim());

      // Store: strobe and data forwarded, no read result
      $display("[TB] store");
      s = idleStim();
      s.mv = 1'b1; s.mw = 1'b1; s.a = 32'h00000010; s.sz = MSIZE2; s.st = 4'b0011; s.wd = 32'h00001234;
      reqQ.push_back('{a: 32'h00000010, sz: MSIZE2, st: 4'b0011, wd: 32'h00001234});
      doAccess(s, 1, 0, 32'hFFFFFFFF, sc, rc, stable);
      checkOutput("t3_stall_cycles", 96'(sc), 96'(2));
      checkOutput("t3_rvalid", 96'(rdataValid), 96'(0));
      checkOutput("t3_rdata_unchanged", 96'(rdata), 96'(32'hCAFEF00D));
      s.adv = 1'b1;
      applyStimulus(s);
      applyStimulus(idleStim());

      // Flush while waiting for data: drain the bus, keep old rdata
      $display("[TB] flush during data phase");
      s = idleStim();
      s.mv = 1'b1; s.a = 32'h00000020; s.sz = MSIZE4; s.aok = 1'b1;
      reqQ.push_back('{a: 32'h00000020, sz: MSIZE4, st: 4'h0, wd: 32'h0});
      applyStimulus(s);
      checkOutput("t4_issue_stall", 96'(stallReq), 96'(1));
      s.aok = 1'b0; s.fl = 1'b1;
      applyStimulus(s);
      checkOutput("t4_flush_stall", 96'(stallReq), 96'(1));
      s = idleStim();
      applyStimulus(s);
      checkOutput("t4_drain_stall", 96'(stallReq), 96'(1));
      checkOutput("t4_drain_no_req", 96'(bus.dreq_valid), 96'(0));
      s.dok = 1'b1; s.rd = 32'h00000055;
      applyStimulus(s);
      checkOutput("t4_drain_dataok_stall", 96'(stallReq), 96'(1));
      applyStimulus(idleStim());
      checkOutput("t4_idle_stall", 96'(stallReq), 96'(0));
      checkOutput("t4_rvalid", 96'(rdataValid), 96'(0));
      checkOutput("t4_rdata_unchanged", 96'(rdata), 96'(32'hCAFEF00D));

      // Back-to-back loads: advance in the first DONE cycle, next issue the cycle after
      $display("[TB] back-to-back loads");
      s = idleStim();
      s.mv = 1'b1; s.a = 32'h00000100; s.sz = MSIZE4; s.aok = 1'b1; s.dok = 1'b1; s.rd = 32'h11111111;
      reqQ.push_back('{a: 32'h00000100, sz: MSIZE4, st: 4'h0, wd: 32'h0});
      respQ.push_back(32'h11111111);
      applyStimulus(s);
      checkOutput("t5_a_stall", 96'(stallReq), 96'(1));
      s.aok = 1'b0; s.dok = 1'b0; s.rd = 32'h0; s.adv = 1'b1;
      applyStimulus(s);
      checkOutput("t5_a_done_stall", 96'(stallReq), 96'(0));
      checkOutput("t5_a_done_no_req", 96'(bus.dreq_valid), 96'(0));
      s = idleStim();
      s.mv = 1'b1; s.a = 32'h00000104; s.sz = MSIZE4;
      reqQ.push_back('{a: 32'h00000104, sz: MSIZE4, st: 4'h0, wd: 32'h0});
      respQ.push_back(32'h22222222);
      applyStimulus(s);
      checkOutput("t5_b_issue", 96'(bus.dreq_valid), 96'(1));
      checkOutput("t5_b_addr", 96'(bus.dreq_addr), 96'(32'h00000104));
      s.aok = 1'b1; s.dok = 1'b1; s.rd = 32'h22222222;
      applyStimulus(s);
      checkOutput("t5_b_addr_phase", 96'(bus.dreq_valid), 96'(1));
      s.aok = 1'b0; s.dok = 1'b0; s.rd = 32'h0;
      applyStimulus(s);
      checkOutput("t5_b_done_rvalid", 96'(rdataValid), 96'(1));
      s.adv = 1'b1;
      applyStimulus(s);
      applyStimulus(idleStim());

      // Synchronous reset while the request is waiting for addr_ok
      $display("[TB] reset during address phase");
      s = idleStim();
      s.mv = 1'b1; s.a = 32'h00000200; s.sz = MSIZE4;
      applyStimulus(s);
      applyStimulus(s);
      checkOutput("t6_addr_phase", 96'(bus.dreq_valid), 96'(1));
      s = idleStim();
      s.rstn = 1'b0;
      applyStimulus(s);
      applyStimulus(s);
      checkOutput("t6_rst_dreq_valid", 96'(bus.dreq_valid), 96'(0));
      checkOutput("t6_rst_stall", 96'(stallReq), 96'(0));
      checkOutput("t6_rst_rvalid", 96'(rdataValid), 96'(0));
      checkOutput("t6_rst_rdata", 96'(rdata), 96'(0));
      applyStimulus(idleStim());

`ifdef DBUS_SEQ_ALIGN_CHECK_EN
      // Misaligned word load is trapped without a bus request
      $display("[TB] misaligned access trap");
      s = idleStim();
      s.mv = 1'b1; s.a = 32'h00000002; s.sz = MSIZE4;
      applyStimulus(s);
      checkOutput("t7_no_req", 96'(bus.dreq_valid), 96'(0));
      checkOutput("t7_no_stall", 96'(stallReq), 96'(0));
      applyStimulus(s);
      checkOutput("t7_misalign", 96'(misalign), 96'(1));
      checkOutput("t7_rvalid", 96'(rdataValid), 96'(0));
      checkOutput("t7_done_no_req", 96'(bus.dreq_valid), 96'(0));
      s.adv = 1'b1;
      applyStimulus(s);
      checkOutput("t7_misalign_hold", 96'(misalign), 96'(1));
      applyStimulus(idleStim());
      checkOutput("t7_misalign_clear", 96'(misalign), 96'(0));
`else
      // Without the trap an unaligned word load is issued as-is
      $display("[TB] unaligned access issued unchecked");
      s = idleStim();
      s.mv = 1'b1; s.a = 32'h00000002; s.sz = MSIZE4;
      reqQ.push_back('{a: 32'h00000002, sz: MSIZE4, st: 4'h0, wd: 32'h0});
      respQ.push_back(32'h33333333);
      doAccess(s, 0, 0, 32'h33333333, sc, rc, stable);
      checkOutput("t7_stall_cycles", 96'(sc), 96'(1));
      s.adv = 1'b1;
      applyStimulus(s);
      applyStimulus(idleStim());
`endif

      applyStimulus(idleStim());
      checkOutput("req_queue_empty", 96'(reqQ.size()), 96'(0));
      checkOutput("resp_queue_empty", 96'(respQ.size()), 96'(0));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
